// File: rtl/alu_mc.sv
// alu_mc: registered Hack-style ALU with carry/overflow flags, valid/ready handshakes and a multi-cycle shift-add multiply
module alu_mc #(
  parameter int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  input  logic             mul,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             zr,
  output logic             ng,
  output logic             cy,
  output logic             ov
);
  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   a_q, a_d, acc_q, acc_d, acc_nxt;
  logic [WIDTH-1:0]     b_q, b_d, o_q, o_d, a_pre, b_pre, add_o, mul_o;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 no_q, no_d, zr_q, zr_d, ng_q, ng_d, cy_q, cy_d, ov_q, ov_d, last;
  logic [WIDTH:0]       sum;
  always_comb begin
    a_pre   = (zx ? '0 : x) ^ {WIDTH{nx}};
    b_pre   = (zy ? '0 : y) ^ {WIDTH{ny}};
    sum     = {1'b0, a_pre} + {1'b0, b_pre};
    add_o   = (f ? sum[WIDTH-1:0] : a_pre & b_pre) ^ {WIDTH{no}};
    acc_nxt = acc_q + (b_q[0] ? a_q : '0);
    mul_o   = acc_nxt[WIDTH-1:0] ^ {WIDTH{no_q}};
    last    = cnt_q == CNT_W'(WIDTH - 1);
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    no_d    = no_q;
    o_d     = o_q;
    zr_d    = zr_q;
    ng_d    = ng_q;
    cy_d    = cy_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: begin
        if (in_valid && mul) begin
          state_d = BUSY;
          a_d     = {{WIDTH{1'b0}}, a_pre};
          b_d     = b_pre;
          acc_d   = '0;
          cnt_d   = '0;
          no_d    = no;
        end else if (in_valid) begin
          state_d = HOLD;
          o_d     = add_o;
          zr_d    = ~|add_o;
          ng_d    = add_o[WIDTH-1];
          cy_d    = f & sum[WIDTH];
          ov_d    = f & (a_pre[WIDTH-1] == b_pre[WIDTH-1]) & (sum[WIDTH-1] != a_pre[WIDTH-1]);
        end
      end
      BUSY: begin
        acc_d = acc_nxt;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          state_d = HOLD;
          o_d     = mul_o;
          zr_d    = ~|mul_o;
          ng_d    = mul_o[WIDTH-1];
          cy_d    = |acc_nxt[2*WIDTH-1:WIDTH];
          ov_d    = 1'b0;
        end
      end
      HOLD: state_d = out_ready ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      no_q    <= 1'b0;
      o_q     <= '0;
      zr_q    <= 1'b0;
      ng_q    <= 1'b0;
      cy_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      no_q    <= no_d;
      o_q     <= o_d;
      zr_q    <= zr_d;
      ng_q    <= ng_d;
      cy_q    <= cy_d;
      ov_q    <= ov_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == HOLD;
  assign o         = o_q;
  assign zr        = zr_q;
  assign ng        = ng_q;
  assign cy        = cy_q;
  assign ov        = ov_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: randomized and directed self-checking bench for alu_mc against an arithmetic reference model
module tb_alu_mc;
  logic        clk = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic        in_ready, out_valid, zr, ng, cy, ov;
  logic        zx = 0, nx = 0, zy = 0, ny = 0, f = 0, no = 0, mul = 0;
  logic [15:0] x = 0, y = 0, o;
  int          errs = 0, checks = 0;
  always #5 clk = ~clk;
  alu_mc #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no), .mul(mul),
    .out_valid(out_valid), .out_ready(out_ready),
    .o(o), .zr(zr), .ng(ng), .cy(cy), .ov(ov)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic [15:0] xv, yv, input logic [6:0] c,
                                output logic [15:0] eo, output logic ecy, eov);
    logic [15:0]     a, b;
    longint unsigned p;
    int              s;
    a = c[6] ? 16'h0 : xv;
    if (c[5]) a = ~a;
    b = c[4] ? 16'h0 : yv;
    if (c[3]) b = ~b;
    if (c[0]) begin
      p = 64'(a) * 64'(b);
      eo = p[15:0]; ecy = p > 64'd65535; eov = 0;
    end else if (c[2]) begin
      p = 64'(a) + 64'(b);
      s = int'($signed(a)) + int'($signed(b));
      eo = p[15:0]; ecy = p > 64'd65535; eov = s > 32767 || s < -32768;
    end else begin
      eo = a & b; ecy = 0; eov = 0;
    end
    if (c[1]) eo = ~eo;
  endfunction
  task automatic run_op(input logic [15:0] xv, yv, input logic [6:0] c, input int hold);
    logic [15:0] eo;
    logic        ecy, eov, busy_rdy, stable;
    int          n, lat;
    model(xv, yv, c, eo, ecy, eov);
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("in_ready_idle", in_ready, 1);
    x = xv; y = yv; {zx, nx, zy, ny, f, no, mul} = c; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    lat = 1; busy_rdy = 0;
    while (!out_valid && lat < 40) begin busy_rdy |= in_ready; @(negedge clk); lat++; end
    chk("latency", lat, c[0] ? 17 : 1);
    chk("busy_in_ready", busy_rdy, 0);
    chk("o", o, eo);
    chk("zr", zr, eo == 16'h0);
    chk("ng", ng, eo[15]);
    chk("cy", cy, ecy);
    chk("ov", ov, eov);
    stable = 1;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      stable &= out_valid && !in_ready && o == eo && zr == (eo == 16'h0) && ng == eo[15] && cy == ecy && ov == eov;
    end
    in_valid = 0;
    if (hold > 0) chk("hold_stable", stable, 1);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("release_valid", out_valid, 0);
    chk("release_ready", in_ready, 1);
  endtask
  initial begin
    logic saw;
    repeat (3) @(negedge clk);
    reset = 0;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_flags", {o, zr, ng, cy, ov}, 0);
    run_op(16'd5, 16'd3, 7'b0000100, 0);
    run_op(16'd3, 16'd5, 7'b0100110, 0);
    run_op(16'd7, 16'd7, 7'b0100110, 0);
    run_op(16'h7FFF, 16'h0001, 7'b0000100, 0);
    run_op(16'hFFFF, 16'h0001, 7'b0000100, 0);
    run_op(16'hF0F0, 16'hFF00, 7'b0000000, 0);
    run_op(16'd300, 16'd300, 7'b0000001, 0);
    run_op(16'd0, 16'd1234, 7'b1000011, 0);
    run_op(16'h1234, 16'h4321, 7'b0000100, 5);
    x = 16'd300; y = 16'd300; {zx, nx, zy, ny, f, no, mul} = 7'b0000001; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (7) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_o", o, 0);
    chk("midrst_ready", in_ready, 1);
    saw = 0;
    repeat (20) begin @(negedge clk); saw |= out_valid; end
    chk("midrst_no_emit", saw, 0);
    run_op(16'd100, 16'd23, 7'b0000100, 0);
    for (int k = 0; k < 40; k++)
      run_op(16'($urandom), 16'($urandom),
             {6'($urandom), 1'($urandom_range(0, 3) == 0)}, int'($urandom_range(0, 3)));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
